// File: rtl/alu_sequencer.sv
// Multi-cycle controller for the 4-bit datapath: fetches operands from a 4-entry
// register file, drives the external registered ALU, waits out its latency and writes back.
module alu_sequencer #(
    parameter int DATA_W      = 4,
    parameter int ALU_LATENCY = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [11:0]       instr,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [3:0]        alu_op,
    input  logic [DATA_W:0]   alu_result,
    input  logic              alu_sign,
    output logic              busy,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              flag_c,
    output logic              flag_n,
    output logic              flag_z
);

    // Handshake: a transfer happens on a rising edge where instr_valid && instr_ready;
    // instr_ready is high only in IDLE, and instr is don't-care at every other edge.

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_LDI = 4'd3;
    localparam logic [3:0] OP_MOV = 4'd4;
    localparam logic [3:0] OP_OUT = 4'd5;

    state_t            state_q, state_d;
    logic [11:0]       instr_q;
    logic [DATA_W-1:0] regs [4];
    logic [2:0]        cnt_q;

    logic [3:0]        op;
    logic [1:0]        rd, rs;
    logic [DATA_W-1:0] imm;

    assign op  = instr_q[11:8];
    assign rd  = instr_q[7:6];
    assign rs  = instr_q[5:4];
    assign imm = DATA_W'(instr_q[3:0]);

    assign instr_ready = (state_q == IDLE);
    assign busy        = (state_q != IDLE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (instr_valid) state_d = DECODE;
            DECODE:  state_d = (op == OP_ADD || op == OP_SUB) ? EXEC : IDLE;
            EXEC:    if (cnt_q <= 3'd1) state_d = WB;
            WB:      state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            instr_q   <= '0;
            cnt_q     <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            flag_c    <= 1'b0;
            flag_n    <= 1'b0;
            flag_z    <= 1'b0;
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            state_q   <= state_d;
            out_valid <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (instr_valid) instr_q <= instr;
                end
                DECODE: begin
                    case (op)
                        OP_ADD, OP_SUB: begin
                            alu_a  <= regs[rd];
                            alu_b  <= regs[rs];
                            alu_op <= op;
                            cnt_q  <= 3'(ALU_LATENCY);
                        end
                        OP_LDI: begin
                            regs[rd] <= imm;
                            flag_z   <= (imm == '0);
                        end
                        OP_MOV: begin
                            regs[rd] <= regs[rs];
                            flag_z   <= (regs[rs] == '0);
                        end
                        OP_OUT: begin
                            out_data  <= regs[rd];
                            out_valid <= 1'b1;
                        end
                        default: ;
                    endcase
                end
                EXEC: begin
                    cnt_q <= cnt_q - 3'd1;
                end
                WB: begin
                    // SUB returns magnitude in the low bits; ADD returns carry in the MSB.
                    regs[rd] <= alu_result[DATA_W-1:0];
                    if (op == OP_ADD) flag_c <= alu_result[DATA_W];
                    else              flag_n <= alu_sign;
                    flag_z <= (alu_result[DATA_W-1:0] == '0);
                    alu_op <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Bench for alu_sequencer: behavioural registered ALU, register/flag model and an
// expected-output queue checked whenever out_valid pulses.
module tb_alu_sequencer;

    localparam int DATA_W = 4;
    localparam int L      = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              instr_valid;
    logic              instr_ready;
    logic [11:0]       instr;
    logic [DATA_W-1:0] alu_a, alu_b;
    logic [3:0]        alu_op;
    logic [DATA_W:0]   alu_result;
    logic              alu_sign;
    logic              busy, out_valid;
    logic [DATA_W-1:0] out_data;
    logic              flag_c, flag_n, flag_z;

    int errors = 0;
    int checks = 0;
    int accepts = 0;
    int out_count = 0;

    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] exp_v;
    logic [3:0]        m_r [4];
    logic              m_c, m_n, m_z;

    alu_sequencer #(.DATA_W(DATA_W), .ALU_LATENCY(L)) dut (
        .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .alu_result(alu_result), .alu_sign(alu_sign), .busy(busy),
        .out_valid(out_valid), .out_data(out_data),
        .flag_c(flag_c), .flag_n(flag_n), .flag_z(flag_z)
    );

    always #5 clk = ~clk;

    // Registered ALU with L pipeline stages
    logic [DATA_W:0] pipe_r [L];
    logic            pipe_s [L];
    always @(posedge clk) begin
        if (alu_op == 4'd1) begin
            pipe_r[0] <= {1'b0, alu_a} + {1'b0, alu_b};
            pipe_s[0] <= 1'b0;
        end else if (alu_op == 4'd2) begin
            pipe_r[0] <= (alu_a >= alu_b) ? {1'b0, alu_a - alu_b} : {1'b0, alu_b - alu_a};
            pipe_s[0] <= (alu_a < alu_b);
        end else begin
            pipe_r[0] <= '0;
            pipe_s[0] <= 1'b0;
        end
        for (int k = 1; k < L; k++) begin
            pipe_r[k] <= pipe_r[k-1];
            pipe_s[k] <= pipe_s[k-1];
        end
    end
    assign alu_result = pipe_r[L-1];
    assign alu_sign   = pipe_s[L-1];

    always @(posedge clk) if (rst_n && instr_valid && instr_ready) accepts++;

    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            out_count++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected: out_data=%0d with no OUT pending", out_data);
            end else begin
                exp_v = exp_q.pop_front();
                if (out_data !== exp_v) begin
                    errors++;
                    $display("FAIL out_data: got %0d expected %0d", out_data, exp_v);
                end
            end
        end
    end

    function automatic logic [11:0] mk(input int op, input int rd, input int rs, input int imm);
        logic [3:0] o, i;
        logic [1:0] d, s;
        o = 4'(op); d = 2'(rd); s = 2'(rs); i = 4'(imm);
        return {o, d, s, i};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) m_r[i] = '0;
        m_c = 1'b0; m_n = 1'b0; m_z = 1'b0;
        exp_q.delete();
    endtask

    task automatic model_apply(input logic [11:0] ins);
        logic [4:0] s;
        logic [3:0] a, b;
        a = m_r[ins[7:6]];
        b = m_r[ins[5:4]];
        case (ins[11:8])
            4'd1: begin s = {1'b0, a} + {1'b0, b}; m_r[ins[7:6]] = s[3:0]; m_c = s[4]; m_z = (s[3:0] == 0); end
            4'd2: begin
                s[3:0] = (a >= b) ? a - b : b - a;
                m_r[ins[7:6]] = s[3:0]; m_n = (a < b); m_z = (s[3:0] == 0);
            end
            4'd3: begin m_r[ins[7:6]] = ins[3:0]; m_z = (ins[3:0] == 0); end
            4'd4: begin m_r[ins[7:6]] = b; m_z = (b == 0); end
            4'd5: exp_q.push_back(a);
            default: ;
        endcase
    endtask

    task automatic issue(input logic [11:0] ins, input bit hold);
        int n;
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        n = 0;
        while (!instr_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) begin
            checks++; errors++;
            $display("FAIL accept_timeout: instr_ready=%b after %0d cycles, required 1", instr_ready, n);
            instr_valid = 1'b0;
        end else begin
            @(posedge clk);
            model_apply(ins);
            #1;
            if (!hold) instr_valid = 1'b0;
        end
    endtask

    task automatic wait_idle(output int cyc);
        cyc = 0;
        @(negedge clk);
        while (busy && cyc < 50) begin
            cyc++;
            @(negedge clk);
        end
        if (busy) begin
            checks++; errors++;
            $display("FAIL idle_timeout: busy=%b after %0d cycles, required 0", busy, cyc);
        end
        repeat (2) @(negedge clk);
    endtask

    task automatic run(input logic [11:0] ins);
        int c;
        issue(ins, 1'b0);
        wait_idle(c);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; instr_valid = 1'b0; instr = '0;
        model_reset();
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, out_valid, flag_c, flag_n, flag_z, alu_op, alu_a, alu_b, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b ov=%b c=%b n=%b z=%b op=%0d a=%0d b=%0d od=%0d, required all 0",
                     busy, out_valid, flag_c, flag_n, flag_z, alu_op, alu_a, alu_b, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_ready: got %b required 1", instr_ready);
        end
    endtask

    task automatic test_sub_out();
        int oc;
        run(mk(3, 0, 0, 5));
        run(mk(3, 1, 0, 3));
        run(mk(2, 0, 1, 0));
        checks++;
        if ({flag_c, flag_n, flag_z} !== 3'b000) begin
            errors++; $display("FAIL sub_pos_flags: got cnz=%b%b%b required 000", flag_c, flag_n, flag_z);
        end
        oc = out_count;
        run(mk(5, 0, 0, 0));
        checks++;
        if (out_count - oc !== 1) begin
            errors++; $display("FAIL out_pulse: got %0d out_valid cycles, required 1", out_count - oc);
        end
    endtask

    task automatic test_sub_neg();
        int cyc;
        run(mk(3, 0, 0, 3));
        run(mk(3, 1, 0, 5));
        issue(mk(2, 0, 1, 0), 1'b0);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if (alu_op !== 4'd2 || alu_a !== 4'd3 || alu_b !== 4'd5) begin
            errors++; $display("FAIL sub_operands: got op=%0d a=%0d b=%0d required 2/3/5", alu_op, alu_a, alu_b);
        end
        wait_idle(cyc);
        // Two busy cycles were already consumed before wait_idle started counting.
        checks++;
        if (cyc + 2 !== 2 + L) begin
            errors++; $display("FAIL sub_busy: got %0d busy cycles required %0d", cyc + 2, 2 + L);
        end
        checks++;
        if ({flag_c, flag_n, flag_z} !== 3'b010) begin
            errors++; $display("FAIL sub_neg_flags: got cnz=%b%b%b required 010", flag_c, flag_n, flag_z);
        end
        run(mk(5, 0, 0, 0));
    endtask

    task automatic test_add_carry();
        run(mk(3, 2, 0, 15));
        run(mk(3, 3, 0, 1));
        run(mk(1, 2, 3, 0));
        checks++;
        if ({flag_c, flag_n, flag_z} !== 3'b111) begin
            errors++; $display("FAIL add_carry_flags: got cnz=%b%b%b required 111", flag_c, flag_n, flag_z);
        end
        run(mk(5, 2, 0, 0));
        checks++;
        if (alu_op !== 4'd0) begin
            errors++; $display("FAIL add_op_cleared: got alu_op=%0d required 0", alu_op);
        end
    endtask

    task automatic test_reset_mid();
        run(mk(3, 0, 0, 3));
        run(mk(3, 1, 0, 5));
        issue(mk(2, 0, 1, 0), 1'b0);
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || alu_op !== 4'd2) begin
            errors++; $display("FAIL mid_exec: got busy=%b op=%0d required 1/2", busy, alu_op);
        end
        rst_n = 1'b0;
        #1;
        model_reset();
        checks++;
        if ({busy, out_valid, flag_c, flag_n, flag_z, alu_op, alu_a, alu_b, out_data} !== '0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got busy=%b c=%b n=%b z=%b op=%0d a=%0d b=%0d od=%0d, required all 0",
                     busy, flag_c, flag_n, flag_z, alu_op, alu_a, alu_b, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (instr_ready !== 1'b1) begin
            errors++; $display("FAIL reset_mid_ready: got %b required 1", instr_ready);
        end
        run(mk(5, 0, 0, 0));
        run(mk(5, 1, 0, 0));
    endtask

    task automatic test_back_to_back();
        int a0, cyc;
        a0 = accepts;
        issue(mk(3, 1, 0, 9), 1'b1);
        issue(mk(1, 1, 1, 0), 1'b1);
        issue(mk(5, 1, 0, 0), 1'b0);
        wait_idle(cyc);
        checks++;
        if (accepts - a0 !== 3) begin
            errors++; $display("FAIL b2b_accepts: got %0d required 3", accepts - a0);
        end
        checks++;
        if ({flag_c, flag_n, flag_z} !== 3'b100) begin
            errors++; $display("FAIL b2b_flags: got cnz=%b%b%b required 100", flag_c, flag_n, flag_z);
        end
    endtask

    task automatic test_nop();
        int cyc;
        logic [11:0] ops [2];
        ops[0] = mk(9, 1, 0, 5);
        ops[1] = mk(0, 1, 1, 0);
        for (int i = 0; i < 2; i++) begin
            issue(ops[i], 1'b0);
            wait_idle(cyc);
            checks++;
            if (cyc !== 1) begin
                errors++; $display("FAIL nop_busy[%0d]: got %0d busy cycles required 1", i, cyc);
            end
            checks++;
            if ({alu_op, flag_c, flag_n, flag_z} !== {4'd0, m_c, m_n, m_z}) begin
                errors++;
                $display("FAIL nop_state[%0d]: got op=%0d cnz=%b%b%b required 0 %b%b%b",
                         i, alu_op, flag_c, flag_n, flag_z, m_c, m_n, m_z);
            end
        end
        run(mk(5, 1, 0, 0));
    endtask

    initial begin
        test_reset();
        test_sub_out();
        test_sub_neg();
        test_add_carry();
        test_reset_mid();
        test_back_to_back();
        test_nop();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() !== 0) begin
            errors++; $display("FAIL pending_outputs: got %0d outstanding, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
